pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage MIPS pipeline. Decides each cycle whether the pipeline advances: continuous run, single-step debug, or halt-drain. Generates PC/IF-ID enables, the shared back-end step enable for the ID/EX, EX/MEM and MEM/WB latches, load-use bubble insertion and jump flush. Sits beside the datapath, driven by the debug unit's commands and by hazard fields tapped from the IF/ID and ID/EX latches.

---
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Central advance sequencer for the 5-stage pipeline: run / single-step / halt-drain.
// Optional load-use stall detection is compiled in when HAZARD_DETECT_EN is defined.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run_cmd,
  input  logic             i_step_cmd,
  input  logic             i_halt_cmd,
  input  logic             i_halt_instr,
  input  logic             i_jump_taken,
  input  logic [4:0]       i_id_rs_addr,
  input  logic [4:0]       i_id_rt_addr,
  input  logic [4:0]       i_ex_rt_addr,
  input  logic             i_ex_memread,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_back_step,
  output logic             o_bubble,
  output logic             o_flush,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t           state_r;
  logic [3:0]       drain_cnt_r;
  logic             step_prev_r;
  logic [CNT_W-1:0] cycle_count_r;

  logic step_edge_s;
  logic hazard_s;
  logic adv_s;
  logic halt_accept_s;

`ifdef HAZARD_DETECT_EN
  assign hazard_s = i_ex_memread & (i_ex_rt_addr != 5'd0) &
                    ((i_ex_rt_addr == i_id_rs_addr) | (i_ex_rt_addr == i_id_rt_addr));
`else
  logic unused_hazard_s;
  assign unused_hazard_s = ^{i_ex_memread, i_ex_rt_addr, i_id_rs_addr, i_id_rt_addr};
  assign hazard_s        = 1'b0;
`endif

  assign step_edge_s   = i_step_cmd & ~step_prev_r;
  assign adv_s         = (state_r == RUN) | (state_r == STEP) | (state_r == DRAIN);
  // A HALT sitting in ID behind a load-use stall is not accepted until the stall clears.
  assign halt_accept_s = i_halt_instr & ~hazard_s;

  // Sequencer state, drain countdown, step edge history and advanced-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      drain_cnt_r   <= 4'd0;
      step_prev_r   <= 1'b0;
      cycle_count_r <= {CNT_W{1'b0}};
    end else begin
      step_prev_r <= i_step_cmd;
      if (adv_s && (cycle_count_r != CNT_MAX)) begin
        cycle_count_r <= cycle_count_r + CNT_ONE;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
      case (state_r)
        IDLE: begin
          if (i_halt_cmd) begin
            state_r <= IDLE;
          end else if (i_run_cmd) begin
            state_r <= RUN;
          end else if (step_edge_s) begin
            state_r <= STEP;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (i_halt_cmd) begin
            state_r <= IDLE;
          end else if (halt_accept_s) begin
            state_r     <= DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end else begin
            state_r <= RUN;
          end
        end
        STEP: begin
          if (halt_accept_s) begin
            state_r     <= DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          drain_cnt_r <= drain_cnt_r - 4'd1;
          if (drain_cnt_r == 4'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r     <= IDLE;
          drain_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Stage enables: Mealy on the hazard/jump inputs while fetching, fixed pattern while draining.
  always_comb begin
    o_pc_en     = 1'b0;
    o_ifid_en   = 1'b0;
    o_back_step = 1'b0;
    o_bubble    = 1'b0;
    o_flush     = 1'b0;
    case (state_r)
      RUN, STEP: begin
        o_back_step = 1'b1;
        o_pc_en     = ~hazard_s;
        o_ifid_en   = ~hazard_s;
        o_bubble    = hazard_s;
        o_flush     = i_jump_taken & ~hazard_s;
      end
      DRAIN: begin
        o_back_step = 1'b1;
        o_bubble    = 1'b1;
      end
      default: begin
        o_back_step = 1'b0;
      end
    endcase
  end

  assign o_state       = state_r;
  assign o_done        = (state_r == DONE);
  assign o_cycle_count = cycle_count_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed sequences, a vector table in RUN,
// and randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif
  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_run_cmd, i_step_cmd, i_halt_cmd, i_halt_instr, i_jump_taken;
  logic [4:0]       i_id_rs_addr, i_id_rt_addr, i_ex_rt_addr;
  logic             i_ex_memread;
  logic             o_pc_en, o_ifid_en, o_back_step, o_bubble, o_flush, o_done;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_run_cmd(i_run_cmd), .i_step_cmd(i_step_cmd), .i_halt_cmd(i_halt_cmd),
    .i_halt_instr(i_halt_instr), .i_jump_taken(i_jump_taken),
    .i_id_rs_addr(i_id_rs_addr), .i_id_rt_addr(i_id_rt_addr),
    .i_ex_rt_addr(i_ex_rt_addr), .i_ex_memread(i_ex_memread),
    .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_back_step(o_back_step),
    .o_bubble(o_bubble), .o_flush(o_flush), .o_state(o_state),
    .o_done(o_done), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    i_run_cmd = 1'b0; i_step_cmd = 1'b0; i_halt_cmd = 1'b0; i_halt_instr = 1'b0;
    i_jump_taken = 1'b0; i_id_rs_addr = 5'd0; i_id_rt_addr = 5'd0;
    i_ex_rt_addr = 5'd0; i_ex_memread = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_pulse();
    @(posedge clk); #1 i_run_cmd = 1'b1;
    @(posedge clk); #1 i_run_cmd = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int          m_state;      // 0 idle, 1 run, 2 step, 3 drain, 4 done
  int          m_drain_left;
  bit          m_step_prev;
  logic [31:0] m_count;

  function automatic bit model_hazard();
    return HZ_EN && i_ex_memread && (i_ex_rt_addr != 5'd0) &&
           ((i_ex_rt_addr == i_id_rs_addr) || (i_ex_rt_addr == i_id_rt_addr));
  endfunction

  task automatic model_reset();
    m_state = 0; m_drain_left = 0; m_step_prev = 1'b0; m_count = 32'd0;
  endtask

  task automatic model_check();
    bit hz, fetching, draining;
    hz       = model_hazard();
    fetching = (m_state == 1) || (m_state == 2);
    draining = (m_state == 3);
    chk("rnd_state",   {29'd0, o_state},     m_state);
    chk("rnd_pc_en",   {31'd0, o_pc_en},     {31'd0, fetching && !hz});
    chk("rnd_ifid_en", {31'd0, o_ifid_en},   {31'd0, fetching && !hz});
    chk("rnd_back",    {31'd0, o_back_step}, {31'd0, fetching || draining});
    chk("rnd_bubble",  {31'd0, o_bubble},    {31'd0, (fetching && hz) || draining});
    chk("rnd_flush",   {31'd0, o_flush},     {31'd0, fetching && i_jump_taken && !hz});
    chk("rnd_done",    {31'd0, o_done},      {31'd0, m_state == 4});
    chk("rnd_count",   o_cycle_count,        m_count);
  endtask

  task automatic model_clock();
    bit edge_s, accept;
    if (!rst) begin
      model_reset();
    end else begin
      edge_s = i_step_cmd && !m_step_prev;
      m_step_prev = i_step_cmd;
      accept = i_halt_instr && !model_hazard();
      if (m_state >= 1 && m_state <= 3 && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      if (m_state == 0) begin
        if (i_halt_cmd) m_state = 0;
        else if (i_run_cmd) m_state = 1;
        else if (edge_s) m_state = 2;
      end else if (m_state == 1) begin
        if (i_halt_cmd) m_state = 0;
        else if (accept) begin m_state = 3; m_drain_left = DRAIN_CYCLES; end
      end else if (m_state == 2) begin
        if (accept) begin m_state = 3; m_drain_left = DRAIN_CYCLES; end
        else m_state = 0;
      end else if (m_state == 3) begin
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_state = 4;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       jump;
    logic       stall;   // load-use stall when detection is built in
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bs_sum;
    logic exp_stall;
    rst = 1'b1;
    clear_inputs();
    vecs[0] = '{1'b1, 5'd8,  5'd8,  5'd3, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd8,  5'd3,  5'd8, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd8,  5'd8,  5'd8, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd8,  5'd3,  5'd4, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 5'd5,  5'd1,  5'd2, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b1, 1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_enables", {27'd0, o_pc_en, o_ifid_en, o_back_step, o_bubble, o_flush}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_count", o_cycle_count, 32'd0);

    // Run latency and counting
    run_pulse();
    @(negedge clk);
    chk("run_state", {29'd0, o_state}, 32'd1);
    chk("run_pc_en", {31'd0, o_pc_en}, 32'd1);
    chk("run_back", {31'd0, o_back_step}, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("run_count10", o_cycle_count, 32'd10);

    // Held step level yields one step
    do_reset();
    @(posedge clk); #1 i_step_cmd = 1'b1;
    bs_sum = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bs_sum += int'(o_back_step);
      if (k == 4) begin @(posedge clk); #1 i_step_cmd = 1'b0; end
    end
    chk("step_once", bs_sum, 32'd1);
    chk("step_count", o_cycle_count, 32'd1);
    chk("step_state", {29'd0, o_state}, 32'd0);

    // Vector table in RUN
    do_reset();
    run_pulse();
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      i_ex_memread = vecs[v].memread; i_ex_rt_addr = vecs[v].ex_rt;
      i_id_rs_addr = vecs[v].rs; i_id_rt_addr = vecs[v].rt; i_jump_taken = vecs[v].jump;
      exp_stall = vecs[v].stall & HZ_EN;
      @(negedge clk);
      chk($sformatf("vec%0d_pc_en", v), {31'd0, o_pc_en}, {31'd0, ~exp_stall});
      chk($sformatf("vec%0d_ifid_en", v), {31'd0, o_ifid_en}, {31'd0, ~exp_stall});
      chk($sformatf("vec%0d_bubble", v), {31'd0, o_bubble}, {31'd0, exp_stall});
      chk($sformatf("vec%0d_back", v), {31'd0, o_back_step}, 32'd1);
      chk($sformatf("vec%0d_flush", v), {31'd0, o_flush}, {31'd0, vecs[v].jump & ~exp_stall});
    end

    // Jump under stall, then stall clears with jump still asserted
    @(posedge clk); #1;
    i_ex_memread = 1'b1; i_ex_rt_addr = 5'd5; i_id_rs_addr = 5'd5; i_id_rt_addr = 5'd0;
    i_jump_taken = 1'b1;
    @(negedge clk);
    chk("jump_stalled_flush", {31'd0, o_flush}, {31'd0, ~HZ_EN});
    @(posedge clk); #1 i_ex_memread = 1'b0;
    @(negedge clk);
    chk("jump_release_flush", {31'd0, o_flush}, 32'd1);
    clear_inputs();

    // HALT accepted in RUN, drain, done, run ignored
    do_reset();
    run_pulse();
    @(posedge clk); #1 i_halt_instr = 1'b1;
    @(posedge clk); #1 i_halt_instr = 1'b0;
    for (int k = 1; k <= DRAIN_CYCLES; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_state", k), {29'd0, o_state}, 32'd3);
      chk($sformatf("drain%0d_pc_en", k), {31'd0, o_pc_en}, 32'd0);
      chk($sformatf("drain%0d_back", k), {31'd0, o_back_step}, 32'd1);
      chk($sformatf("drain%0d_bubble", k), {31'd0, o_bubble}, 32'd1);
      chk($sformatf("drain%0d_done", k), {31'd0, o_done}, 32'd0);
    end
    @(negedge clk);
    chk("done_flag", {31'd0, o_done}, 32'd1);
    chk("done_state", {29'd0, o_state}, 32'd4);
    chk("done_back", {31'd0, o_back_step}, 32'd0);
    run_pulse();
    @(negedge clk);
    chk("done_run_ignored", {29'd0, o_state}, 32'd4);

    // Reset in the middle of DRAIN
    do_reset();
    run_pulse();
    @(posedge clk); #1 i_halt_instr = 1'b1;
    @(posedge clk); #1 i_halt_instr = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("drain_rst_state", {29'd0, o_state}, 32'd0);
    chk("drain_rst_enables", {27'd0, o_pc_en, o_ifid_en, o_back_step, o_bubble, o_flush}, 32'd0);
    chk("drain_rst_count", o_cycle_count, 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(99) >= 2);
      i_run_cmd    = ($urandom_range(99) < 10);
      i_step_cmd   = ($urandom_range(99) < 30);
      i_halt_cmd   = ($urandom_range(99) < 8);
      i_halt_instr = ($urandom_range(99) < 4);
      i_jump_taken = ($urandom_range(99) < 25);
      i_ex_memread = ($urandom_range(99) < 40);
      i_ex_rt_addr = 5'($urandom_range(3));
      i_id_rs_addr = 5'($urandom_range(3));
      i_id_rt_addr = 5'($urandom_range(3));
      @(negedge clk);
      model_check();
      model_clock();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
